// File: rtl/ica_pkg.sv
// Shared constants and state encoding for the FastICA convergence/norm blocks.
package ica_pkg;

    localparam int DW       = 26;
    localparam int THRESH   = 256;
    localparam int MAX_ITER = 64;
    localparam int IW       = 7;
    localparam int N_ELEM   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

endpackage

// File: rtl/abs_sat.sv
// Signed two's-complement to unsigned magnitude; the most negative code clamps to the
// largest positive code so the result always fits in W bits.
module abs_sat
    import ica_pkg::*;
#(
    parameter int W = DW
) (
    input  logic signed [W-1:0] x_i,
    output logic        [W-1:0] abs_o
);

    always_comb begin
        if (x_i == {1'b1, {(W-1){1'b0}}})
            abs_o = {1'b0, {(W-1){1'b1}}};
        else if (x_i[W-1])
            abs_o = $unsigned(-x_i);
        else
            abs_o = $unsigned(x_i);
    end

endmodule

// File: rtl/error_conv_check.sv
// Convergence detector: latches a 4x4 error matrix, scans max |e| serially and
// tracks converged / timeout / iteration count for the FastICA loop.
//
// state   | meaning
// IDLE    | waiting for start_chk (blocked while converged or timeout)
// SCAN    | one shadow element per cycle through abs_sat, index 0..15
// DONE    | one-cycle result pulse, then back to IDLE
module error_conv_check
    import ica_pkg::*;
(
    input  logic                 clk_chk,
    input  logic                 rstn_chk,
    input  logic                 start_chk,
    input  logic                 clr_iter,
    input  logic signed [DW-1:0] e_11, e_12, e_13, e_14,
    input  logic signed [DW-1:0] e_21, e_22, e_23, e_24,
    input  logic signed [DW-1:0] e_31, e_32, e_33, e_34,
    input  logic signed [DW-1:0] e_41, e_42, e_43, e_44,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic                 timeout,
    output logic [DW-1:0]        max_err,
    output logic [IW-1:0]        iter_cnt
);

    chk_state_e          state_q, state_d;
    logic signed [DW-1:0] e_in     [N_ELEM];
    logic signed [DW-1:0] shadow_q [N_ELEM];
    logic [3:0]          idx_q;
    logic [DW-1:0]       run_max_q, max_err_q, elem_abs, run_max_nx;
    logic                conv_q, tout_q, conv_nx, tout_nx, start_ok, last_elem;
    logic [IW-1:0]       iter_q, iter_sat;
    logic [IW:0]         iter_inc;

    assign e_in = '{e_11, e_12, e_13, e_14, e_21, e_22, e_23, e_24,
                    e_31, e_32, e_33, e_34, e_41, e_42, e_43, e_44};

    abs_sat #(.W(DW)) u_abs (
        .x_i   (shadow_q[idx_q]),
        .abs_o (elem_abs)
    );

    assign start_ok   = (state_q == ST_IDLE) && start_chk && !conv_q && !tout_q && !clr_iter;
    assign last_elem  = (state_q == ST_SCAN) && (idx_q == 4'd15);
    assign run_max_nx = (elem_abs > run_max_q) ? elem_abs : run_max_q;
    assign conv_nx    = run_max_nx < DW'(THRESH);
    assign iter_inc   = {1'b0, iter_q} + (IW+1)'(1);
    assign iter_sat   = (iter_inc >= (IW+1)'(MAX_ITER)) ? IW'(MAX_ITER) : iter_inc[IW-1:0];
    assign tout_nx    = !conv_nx && (iter_inc >= (IW+1)'(MAX_ITER));

    always_ff @(posedge clk_chk or negedge rstn_chk) begin
        if (!rstn_chk)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_iter) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok)  state_d = ST_SCAN;
                ST_SCAN: if (last_elem) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_SCAN);
        done = (state_q == ST_DONE) && !clr_iter;
    end

    // Result registers load on the final scan cycle so they are valid alongside done.
    always_ff @(posedge clk_chk or negedge rstn_chk) begin
        if (!rstn_chk) begin
            for (int i = 0; i < N_ELEM; i++) shadow_q[i] <= '0;
            idx_q     <= '0;
            run_max_q <= '0;
            max_err_q <= '0;
            iter_q    <= '0;
            conv_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                for (int i = 0; i < N_ELEM; i++) shadow_q[i] <= e_in[i];
                idx_q     <= '0;
                run_max_q <= '0;
            end else if (state_q == ST_SCAN && !clr_iter) begin
                run_max_q <= run_max_nx;
                idx_q     <= idx_q + 4'd1;
            end

            if (clr_iter) begin
                iter_q <= '0;
                conv_q <= 1'b0;
                tout_q <= 1'b0;
            end else if (last_elem) begin
                max_err_q <= run_max_nx;
                iter_q    <= iter_sat;
                conv_q    <= conv_nx;
                tout_q    <= tout_nx;
            end
        end
    end

    assign max_err   = max_err_q;
    assign iter_cnt  = iter_q;
    assign converged = conv_q;
    assign timeout   = tout_q;

endmodule

// File: tb/tb_error_conv_check.sv
// Self-checking bench for error_conv_check: directed table, corner sequences and a
// randomized run against a behavioural model of the convergence loop.
module tb_error_conv_check;
    import ica_pkg::*;

    logic                 clk_chk = 1'b0;
    logic                 rstn_chk, start_chk, clr_iter;
    logic signed [DW-1:0] e [N_ELEM];
    logic                 busy, done, converged, timeout;
    logic [DW-1:0]        max_err;
    logic [IW-1:0]        iter_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    int m_iter;
    bit m_conv, m_tout;

    typedef struct {
        string  name;
        int     base;
        int     idx;
        int     val;
        longint exp_max;
        bit     exp_conv;
    } vec_t;
    vec_t tbl[6];

    error_conv_check dut (
        .clk_chk(clk_chk), .rstn_chk(rstn_chk), .start_chk(start_chk), .clr_iter(clr_iter),
        .e_11(e[0]),  .e_12(e[1]),  .e_13(e[2]),  .e_14(e[3]),
        .e_21(e[4]),  .e_22(e[5]),  .e_23(e[6]),  .e_24(e[7]),
        .e_31(e[8]),  .e_32(e[9]),  .e_33(e[10]), .e_34(e[11]),
        .e_41(e[12]), .e_42(e[13]), .e_43(e[14]), .e_44(e[15]),
        .busy(busy), .done(done), .converged(converged), .timeout(timeout),
        .max_err(max_err), .iter_cnt(iter_cnt)
    );

    always #5 clk_chk = ~clk_chk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Magnitude with saturation of the most negative code, computed from the values.
    function automatic longint ref_max();
        longint mx = 0;
        longint lim = (longint'(1) << (DW-1)) - 1;
        for (int i = 0; i < N_ELEM; i++) begin
            longint v = e[i];
            longint a = (v < 0) ? -v : v;
            if (a > lim) a = lim;
            if (a > mx) mx = a;
        end
        return mx;
    endfunction

    task automatic model_done(input longint mx);
        m_iter = (m_iter + 1 > MAX_ITER) ? MAX_ITER : m_iter + 1;
        m_conv = (mx < THRESH);
        m_tout = !m_conv && (m_iter >= MAX_ITER);
    endtask

    task automatic do_clr();
        @(negedge clk_chk);
        clr_iter = 1'b1;
        @(negedge clk_chk);
        clr_iter = 1'b0;
        m_iter = 0; m_conv = 0; m_tout = 0;
    endtask

    // Returns positioned at the negedge of cycle 1 (cycle 0 = start sampled).
    task automatic run_start();
        @(negedge clk_chk);
        start_chk = 1'b1;
        @(negedge clk_chk);
        start_chk = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int lat);
        lat = -1;
        for (int k = k0; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk_chk);
        end
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk_chk);
            if (done) c++;
        end
    endtask

    task automatic fill(input int base, input int idx, input int val);
        for (int i = 0; i < N_ELEM; i++) e[i] = DW'(base);
        e[idx] = DW'(val);
    endtask

    initial begin
        int lat, c;
        longint mx;
        logic signed [DW-1:0] minv;
        minv = {1'b1, {(DW-1){1'b0}}};

        tbl[0] = '{"zero",       0,    0,  0,         0,        1'b1};
        tbl[1] = '{"e23_neg300", 10,   6,  -300,      300,      1'b0};
        tbl[2] = '{"e44_thresh", 0,    15, 256,       256,      1'b0};
        tbl[3] = '{"e31_min",    0,    8,  -33554432, 33554431, 1'b0};
        tbl[4] = '{"below_thr",  -255, 3,  255,       255,      1'b1};
        tbl[5] = '{"max_pos",    5,    0,  33554431,  33554431, 1'b0};

        rstn_chk = 1'b0; start_chk = 1'b0; clr_iter = 1'b0;
        fill(0, 0, 0);
        m_iter = 0; m_conv = 0; m_tout = 0;
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_conv", 64'(converged), 0);
        check("rst_tout", 64'(timeout), 0);
        check("rst_max", 64'(max_err), 0);
        check("rst_iter", 64'(iter_cnt), 0);
        repeat (3) @(negedge clk_chk);
        rstn_chk = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_clr();
            fill(tbl[v].base, tbl[v].idx, tbl[v].val);
            run_start();
            check({tbl[v].name, "_busy_c1"}, 64'(busy), 1);
            wait_done(1, lat);
            check({tbl[v].name, "_lat"}, lat, 17);
            check({tbl[v].name, "_max"}, 64'(max_err), tbl[v].exp_max);
            check({tbl[v].name, "_conv"}, 64'(converged), 64'(tbl[v].exp_conv));
            check({tbl[v].name, "_tout"}, 64'(timeout), 0);
            check({tbl[v].name, "_iter"}, 64'(iter_cnt), 1);
            @(negedge clk_chk);
            check({tbl[v].name, "_done_1cyc"}, 64'(done), 0);
            check({tbl[v].name, "_busy_end"}, 64'(busy), 0);
            if (tbl[v].exp_conv) begin
                run_start();
                count_done(25, c);
                check({tbl[v].name, "_start_after_conv"}, c, 0);
                check({tbl[v].name, "_iter_hold"}, 64'(iter_cnt), 1);
            end
        end

        // Timeout after MAX_ITER non-converging scans
        do_clr();
        fill(0, 0, 1000);
        for (int n = 1; n <= MAX_ITER; n++) begin
            run_start();
            wait_done(1, lat);
            check("to_lat", lat, 17);
            if (n == MAX_ITER - 1) check("to_not_yet", 64'(timeout), 0);
        end
        check("to_timeout", 64'(timeout), 1);
        check("to_conv", 64'(converged), 0);
        check("to_iter", 64'(iter_cnt), MAX_ITER);
        run_start();
        count_done(25, c);
        check("to_65th_ignored", c, 0);
        check("to_iter_sat", 64'(iter_cnt), MAX_ITER);
        do_clr();
        check("to_clr_iter", 64'(iter_cnt), 0);
        check("to_clr_tout", 64'(timeout), 0);
        check("to_clr_max_kept", 64'(max_err), 1000);

        // Reset asserted mid-scan
        fill(10, 6, -300);
        run_start();
        wait_done(1, lat);
        check("mr_first_max", 64'(max_err), 300);
        run_start();
        repeat (7) @(negedge clk_chk);
        rstn_chk = 1'b0;
        #1;
        check("mr_busy", 64'(busy), 0);
        check("mr_max", 64'(max_err), 0);
        check("mr_iter", 64'(iter_cnt), 0);
        check("mr_done", 64'(done), 0);
        @(negedge clk_chk);
        rstn_chk = 1'b1;
        count_done(25, c);
        check("mr_no_done", c, 0);
        m_iter = 0; m_conv = 0; m_tout = 0;

        // Start pulse while busy is ignored
        fill(5, 3, -1000);
        run_start();
        @(negedge clk_chk);
        for (int i = 0; i < N_ELEM; i++) e[i] = DW'(1 << 24);
        start_chk = 1'b1;
        @(negedge clk_chk);
        start_chk = 1'b0;
        wait_done(3, lat);
        check("sb_lat", lat, 17);
        check("sb_max", 64'(max_err), 1000);
        count_done(25, c);
        check("sb_single_done", c, 0);

        // clr_iter and start in the same cycle: clear wins
        @(negedge clk_chk);
        clr_iter = 1'b1; start_chk = 1'b1;
        @(negedge clk_chk);
        clr_iter = 1'b0; start_chk = 1'b0;
        check("cs_busy", 64'(busy), 0);
        count_done(25, c);
        check("cs_no_done", c, 0);
        check("cs_iter", 64'(iter_cnt), 0);
        m_iter = 0; m_conv = 0; m_tout = 0;

        // Randomized scans against the model
        for (int r = 0; r < 40; r++) begin
            int mode;
            if ($urandom_range(3) == 0) do_clr();
            mode = $urandom_range(3);
            for (int i = 0; i < N_ELEM; i++) begin
                logic [31:0] rv;
                rv = $urandom;
                if (mode == 0) e[i] = DW'(int'($urandom_range(510)) - 255);
                else           e[i] = $signed(rv[DW-1:0]);
            end
            if (mode != 0 && $urandom_range(7) == 0) e[$urandom_range(15)] = minv;
            mx = ref_max();
            if (!m_conv && !m_tout) begin
                run_start();
                wait_done(1, lat);
                model_done(mx);
                check("rnd_lat", lat, 17);
                check("rnd_max", 64'(max_err), mx);
                check("rnd_conv", 64'(converged), 64'(m_conv));
                check("rnd_tout", 64'(timeout), 64'(m_tout));
                check("rnd_iter", 64'(iter_cnt), m_iter);
            end else begin
                run_start();
                count_done(25, c);
                check("rnd_blocked", c, 0);
                check("rnd_iter_hold", 64'(iter_cnt), m_iter);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
